vending_machine_mx: RTL

//   Parametrised successor to the single-product vending controller. Supports NUM_ITEMS products

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_stock_bank.sv | 40 ++++
 rtl/vending_machine_mx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin/change helpers for the multi-item vending controller.
// Latency: none (types, constants and a pure function).
// Backpressure: none; consumers are purely cycle-driven.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1U   = 2'b01;
    localparam logic [1:0] COIN_2U   = 2'b10;
    localparam logic [1:0] COIN_5U   = 2'b11;

    localparam logic [1:0] CHG_NONE  = 2'b00;
    localparam logic [1:0] CHG_1U    = 2'b01;
    localparam logic [1:0] CHG_2U    = 2'b10;

    // Credit units carried by a coin acceptor code.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1U: return 3'd1;
            COIN_2U: return 3'd2;
            COIN_5U: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with single-index decrement and global reload.
// Latency: updates on the clock edge; sold_out reflects the registered counters.
// Backpressure: none; a decrement of an empty counter is silently dropped.
module vend_stock_bank #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_en,
    input  logic [SEL_W-1:0]     dec_idx,
    input  logic                 reload,
    output logic [NUM_ITEMS-1:0] sold_out
);

    logic [STOCK_W-1:0] stock [NUM_ITEMS];

    // Reload wins over decrement; counters saturate at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (reload)
                    stock[i] <= STOCK_W'(INIT_STOCK);
                else if (dec_en && (int'(dec_idx) == i) && (stock[i] != '0))
                    stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    // Empty flags straight off the counters.
    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock[i] == '0);
    end

endmodule

// File: rtl/vending_machine_mx.sv
// Multi-item vending controller: credit, buy/deny, cancel refund and coin-by-coin change.
// Latency: buy edge N -> dispense in cycle N+1 -> first change coin in cycle N+2.
// Backpressure: none; coins arriving while busy or overflowing credit are bounced via coin_reject.
module vending_machine_mx
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int BAL_W      = 5,
    parameter int MAX_BAL    = 20,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    parameter logic [NUM_ITEMS*BAL_W-1:0] PRICES = {5'd6, 5'd5, 5'd4, 5'd3},
    localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           coin,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 buy,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 dispense,
    output logic [SEL_W-1:0]     item_id,
    output logic [1:0]           change,
    output logic                 deny,
    output logic                 coin_reject,
    output logic                 busy,
    output logic [BAL_W-1:0]     balance,
    output logic [NUM_ITEMS-1:0] sold_out
);

    state_t             state;
    logic [BAL_W-1:0]   price_sel;
    logic               stock_ok;
    logic               sel_ok;
    logic [BAL_W:0]     coin_sum;
    logic               coin_fits;
    logic               coin_seen;
    logic               take_cancel;
    logic               vend_go;
    logic               stock_reload;
    logic [1:0]         chg_code;
    logic [BAL_W-1:0]   chg_amt;

    // Price and availability of the selected item; out-of-range selects are never purchasable.
    always_comb begin
        price_sel = '0;
        stock_ok  = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(sel) == i) begin
                price_sel = PRICES[i*BAL_W +: BAL_W];
                stock_ok  = !sold_out[i];
            end
        end
    end

    assign sel_ok    = (int'(sel) < NUM_ITEMS);
    // One extra bit so the overflow check cannot wrap.
    assign coin_sum  = {1'b0, balance} + (BAL_W+1)'(coin_value(coin));
    assign coin_fits = (coin_sum <= (BAL_W+1)'(MAX_BAL));
    assign coin_seen = (coin != COIN_NONE);

    assign take_cancel  = cancel && (state == CREDIT);
    assign vend_go      = ((state == IDLE) || (state == CREDIT)) && !take_cancel && buy &&
                          sel_ok && stock_ok && (balance >= price_sel);
    assign stock_reload = restock && (state == IDLE) && !vend_go;

    // Largest returnable coin first, so change drains in as few cycles as possible.
    assign chg_code = (balance >= BAL_W'(2)) ? CHG_2U : CHG_1U;
    assign chg_amt  = (balance >= BAL_W'(2)) ? BAL_W'(2) : BAL_W'(1);

    assign busy = (state == VEND) || (state == CHANGE);

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .dec_en   (vend_go),
        .dec_idx  (sel),
        .reload   (stock_reload),
        .sold_out (sold_out)
    );

    // Controller FSM: price is charged on the buy edge so VEND already shows the residual.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            balance     <= '0;
            dispense    <= 1'b0;
            item_id     <= '0;
            change      <= CHG_NONE;
            deny        <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            dispense    <= 1'b0;
            item_id     <= '0;
            change      <= CHG_NONE;
            deny        <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (take_cancel) begin
                        state       <= CHANGE;
                        change      <= chg_code;
                        balance     <= balance - chg_amt;
                        coin_reject <= coin_seen;
                    end else if (vend_go) begin
                        state       <= VEND;
                        dispense    <= 1'b1;
                        item_id     <= sel;
                        balance     <= balance - price_sel;
                        coin_reject <= coin_seen;
                    end else begin
                        deny <= buy;
                        if (coin_seen) begin
                            if (coin_fits) begin
                                balance <= coin_sum[BAL_W-1:0];
                                state   <= CREDIT;
                            end else begin
                                coin_reject <= 1'b1;
                            end
                        end
                    end
                end
                VEND: begin
                    coin_reject <= coin_seen;
                    if (balance != '0) begin
                        state   <= CHANGE;
                        change  <= chg_code;
                        balance <= balance - chg_amt;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    coin_reject <= coin_seen;
                    if (balance != '0) begin
                        change  <= chg_code;
                        balance <= balance - chg_amt;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
